// File: rtl/div_arbiter.sv
// Shared signed restoring divider with a two-requester round-robin front end.
// One request is accepted in IDLE, 8 magnitude steps run in CALC, and FIX applies signs and reports.
module div_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             req1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] Cociente,
    output logic [WIDTH-1:0] Residuo,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic             r_last;
    logic             r_owner;
    logic             r_signA;
    logic             r_signB;
    logic             r_bZero;
    logic [WIDTH-1:0] r_A;
    logic [WIDTH-1:0] r_magB;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_step;

    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [WIDTH-1:0] r_cociente;
    logic [WIDTH-1:0] r_residuo;
    logic             r_divZero;

    logic             w_start;
    logic             w_pick1;
    logic [WIDTH-1:0] w_selA;
    logic [WIDTH-1:0] w_selB;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_quotSigned;
    logic [WIDTH-1:0] w_remSigned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // r_last holds the requester served most recently; on a tie the other one wins.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_pick1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_start     = 1'b1;
                    w_pick1     = req1 && (!req0 || !r_last);
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (r_step == LAST_STEP) begin
                    w_nextState = FIX;
                end
            end
            FIX: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_selA       = w_pick1 ? A1 : A0;
        w_selB       = w_pick1 ? B1 : B0;
        w_magA       = w_selA[WIDTH-1] ? (~w_selA + 1'b1) : w_selA;
        w_magB       = w_selB[WIDTH-1] ? (~w_selB + 1'b1) : w_selB;
        w_shift      = {r_rem, r_quot[WIDTH-1]};
        w_fits       = w_shift >= {1'b0, r_magB};
        w_sub        = w_shift[WIDTH-1:0] - r_magB;
        w_quotSigned = (r_signA ^ r_signB) ? (~r_quot + 1'b1) : r_quot;
        w_remSigned  = r_signA ? (~r_rem + 1'b1) : r_rem;
    end

    // Dividend magnitude shifts out of r_quot MSB-first while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_bZero    <= 1'b0;
            r_A        <= '0;
            r_magB     <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_step     <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_cociente <= '0;
            r_residuo  <= '0;
            r_divZero  <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_owner <= w_pick1;
                        r_gnt0  <= !w_pick1;
                        r_gnt1  <= w_pick1;
                        r_A     <= w_selA;
                        r_signA <= w_selA[WIDTH-1];
                        r_signB <= w_selB[WIDTH-1];
                        r_bZero <= (w_selB == '0);
                        r_magB  <= w_magB;
                        r_quot  <= w_magA;
                        r_rem   <= '0;
                        r_step  <= '0;
                    end
                end
                CALC: begin
                    r_rem  <= w_fits ? w_sub : w_shift[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], w_fits};
                    r_step <= r_step + 1'b1;
                end
                FIX: begin
                    // A zero divisor still costs full latency; the result is forced here.
                    r_cociente <= r_bZero ? '1 : w_quotSigned;
                    r_residuo  <= r_bZero ? r_A : w_remSigned;
                    r_divZero  <= r_bZero;
                    r_done0    <= !r_owner;
                    r_done1    <= r_owner;
                    r_last     <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign Cociente = r_cociente;
    assign Residuo  = r_residuo;
    assign div_zero = r_divZero;
    assign busy     = (r_state == CALC) || (r_state == FIX);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter: signed cases, boundaries,
// round-robin contention, operand stability, mid-operation reset and idle hold.
module tb_div_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] A0 = '0;
    logic [7:0] B0 = '0;
    logic [7:0] A1 = '0;
    logic [7:0] B1 = '0;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] Cociente;
    logic [7:0] Residuo;
    logic       div_zero;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    div_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .A0(A0), .B0(B0),
        .req1(req1), .A1(A1), .B1(B1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .Cociente(Cociente), .Residuo(Residuo), .div_zero(div_zero), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    // Issues one request, drops it after the grant, and reports latency (-1 on timeout).
    task automatic do_div(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          output bit gotGnt, output int lat,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
        gotGnt = 1'b0;
        lat    = -1;
        if (sel) begin
            req1 = 1'b1; A1 = a; B1 = b;
        end else begin
            req0 = 1'b1; A0 = a; B0 = b;
        end
        for (int i = 0; i < 6 && !gotGnt; i++) begin
            tick();
            if ((sel ? gnt1 : gnt0) === 1'b1) gotGnt = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (gotGnt) begin
            for (int n = 1; n <= 20 && lat < 0; n++) begin
                tick();
                if ((sel ? done1 : done0) === 1'b1) lat = n;
            end
        end
        q = Cociente;
        r = Residuo;
        z = div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        compared++;
        if ({gnt0, gnt1, done0, done1, div_zero, busy} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {gnt0, gnt1, done0, done1, div_zero, busy});
        end
        compared++;
        if (Cociente !== 8'h00 || Residuo !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_results: got %h/%h expected 00/00", Cociente, Residuo);
        end
        rst = 1'b0;
    endtask

    task automatic test_signed();
        logic [7:0] ta [4] = '{8'hE2, 8'hC8, 8'h38, 8'h64};
        logic [7:0] tb [4] = '{8'h04, 8'hE9, 8'h03, 8'hF9};
        logic [7:0] eq [4] = '{8'hF9, 8'h02, 8'h12, 8'hF2};
        logic [7:0] er [4] = '{8'hFE, 8'hF6, 8'h02, 8'h02};
        bit g; int lat; logic [7:0] q, r; logic z;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            do_div(1'b0, ta[i], tb[i], g, lat, q, r, z);
            compared++;
            if (!g || lat !== 9) begin
                mismatched++;
                $display("[TB] FAIL signed%0d_latency: got gnt=%0d lat=%0d expected gnt=1 lat=9", i, g, lat);
            end
            compared++;
            if (q !== eq[i] || r !== er[i] || z !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL signed%0d_result: got %h/%h z=%b expected %h/%h z=0", i, q, r, z, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [3] = '{8'h80, 8'h2D, 8'hFC};
        logic [7:0] tb [3] = '{8'hFF, 8'h00, 8'h02};
        logic [7:0] eq [3] = '{8'h80, 8'hFF, 8'hFE};
        logic [7:0] er [3] = '{8'h00, 8'h2D, 8'h00};
        logic       ez [3] = '{1'b0, 1'b1, 1'b0};
        bit g; int lat; logic [7:0] q, r; logic z;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            do_div(1'b0, ta[i], tb[i], g, lat, q, r, z);
            compared++;
            if (!g || lat !== 9) begin
                mismatched++;
                $display("[TB] FAIL bound%0d_latency: got gnt=%0d lat=%0d expected gnt=1 lat=9", i, g, lat);
            end
            compared++;
            if (q !== eq[i] || r !== er[i] || z !== ez[i]) begin
                mismatched++;
                $display("[TB] FAIL bound%0d_result: got %h/%h z=%b expected %h/%h z=%b", i, q, r, z, eq[i], er[i], ez[i]);
            end
        end
    endtask

    task automatic test_contention();
        bit gOwner [4];
        int gCyc [4];
        int nG = 0;
        int nD = 0;
        bit lastOwner = 1'b0;
        A0 = 8'd20; B0 = 8'd6;
        A1 = 8'hF7; B1 = 8'd4;
        req0 = 1'b1;
        req1 = 1'b1;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            tick();
            compared++;
            if ((gnt0 && gnt1) || (done0 && done1) || ((gnt0 || gnt1) && (done0 || done1))) begin
                mismatched++;
                $display("[TB] FAIL contention_exclusive: cycle %0d got gnt=%b%b done=%b%b expected at most one", cyc, gnt0, gnt1, done0, done1);
            end
            if (gnt0 || gnt1) begin
                if (nG < 4) begin
                    gOwner[nG] = gnt1;
                    gCyc[nG]   = cyc;
                end
                lastOwner = gnt1;
                nG++;
                if (nG == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (done0 || done1) begin
                nD++;
                compared++;
                if (done1 !== lastOwner) begin
                    mismatched++;
                    $display("[TB] FAIL contention_done_owner: got done1=%b expected %b", done1, lastOwner);
                end
                compared++;
                if (done0 && (Cociente !== 8'h03 || Residuo !== 8'h02)) begin
                    mismatched++;
                    $display("[TB] FAIL contention_result0: got %h/%h expected 03/02", Cociente, Residuo);
                end else if (done1 && (Cociente !== 8'hFE || Residuo !== 8'hFF)) begin
                    mismatched++;
                    $display("[TB] FAIL contention_result1: got %h/%h expected fe/ff", Cociente, Residuo);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        compared++;
        if (nG !== 4 || nD !== 4) begin
            mismatched++;
            $display("[TB] FAIL contention_counts: got grants=%0d dones=%0d expected 4/4", nG, nD);
        end else begin
            compared++;
            if (gOwner[0] !== 1'b0 || gOwner[1] !== 1'b1 || gOwner[2] !== 1'b0 || gOwner[3] !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL contention_order: got %b%b%b%b expected 0101", gOwner[0], gOwner[1], gOwner[2], gOwner[3]);
            end
            compared++;
            if (gCyc[1] - gCyc[0] !== 10 || gCyc[2] - gCyc[1] !== 10 || gCyc[3] - gCyc[2] !== 10) begin
                mismatched++;
                $display("[TB] FAIL contention_spacing: got %0d,%0d,%0d,%0d expected 10 apart", gCyc[0], gCyc[1], gCyc[2], gCyc[3]);
            end
        end
    endtask

    task automatic test_operand_change();
        bit g = 1'b0;
        int lat = -1;
        do_reset();
        req0 = 1'b1; A0 = 8'd77; B0 = 8'd5;
        for (int i = 0; i < 6 && !g; i++) begin
            tick();
            if (gnt0 === 1'b1) g = 1'b1;
        end
        A0 = 8'd0; B0 = 8'd0; req0 = 1'b0;
        if (g) begin
            for (int n = 1; n <= 20 && lat < 0; n++) begin
                tick();
                if (done0 === 1'b1) lat = n;
            end
        end
        compared++;
        if (!g || lat !== 9) begin
            mismatched++;
            $display("[TB] FAIL opchange_latency: got gnt=%0d lat=%0d expected gnt=1 lat=9", g, lat);
        end
        compared++;
        if (Cociente !== 8'h0F || Residuo !== 8'h02 || div_zero !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL opchange_result: got %h/%h z=%b expected 0f/02 z=0", Cociente, Residuo, div_zero);
        end
    endtask

    task automatic test_reset_midop();
        bit g = 1'b0;
        int doneCount = 0;
        int lat; logic [7:0] q, r; logic z;
        req1 = 1'b1; A1 = 8'd56; B1 = 8'd3;
        for (int i = 0; i < 6 && !g; i++) begin
            tick();
            if (gnt1 === 1'b1) g = 1'b1;
        end
        req1 = 1'b0;
        compared++;
        if (!g) begin
            mismatched++;
            $display("[TB] FAIL midop_grant: got gnt1=0 expected 1");
        end
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        compared++;
        if ({busy, done0, done1, gnt0, gnt1, div_zero} !== 6'b0 || Cociente !== 8'h00 || Residuo !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL midop_cleared: got busy=%b done=%b%b q=%h r=%h z=%b expected all 0", busy, done0, done1, Cociente, Residuo, div_zero);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 || done1) doneCount++;
        end
        compared++;
        if (doneCount !== 0) begin
            mismatched++;
            $display("[TB] FAIL midop_no_done: got %0d done pulses expected 0", doneCount);
        end
        do_div(1'b1, 8'd30, 8'd7, g, lat, q, r, z);
        compared++;
        if (!g || lat !== 9 || q !== 8'h04 || r !== 8'h02 || z !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_restart: got gnt=%0d lat=%0d %h/%h z=%b expected 1/9 04/02 z=0", g, lat, q, r, z);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            tick();
            compared++;
            if ({busy, gnt0, gnt1, done0, done1} !== 5'b0 || Cociente !== 8'h04 || Residuo !== 8'h02 || div_zero !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_hold: cycle %0d got busy=%b gnt=%b%b done=%b%b %h/%h expected 0 00 00 04/02", i, busy, gnt0, gnt1, done0, done1, Cociente, Residuo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_boundaries();
        test_contention();
        test_operand_change();
        test_reset_midop();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
